// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction cache responder: word width,
// zero word and FSM state encodings.
package icache_responder_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Combinational read port, single write port (word write, tag+valid write, flush-clear).
module icache_line_store #(
    parameter int W          = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = W - IDX_W - OFF_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [W-1:0]     rd_data,
    input  logic             wr_word_en,
    input  logic             wr_line_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [W-1:0]     wr_data,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_ram  [LINES];
    logic [W-1:0]     data_ram [LINES][LINE_WORDS];

    // A completing refill wins over a simultaneous flush: its data is fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (flush) begin
                valid <= '0;
            end
            if (wr_line_en) begin
                valid[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_word_en) begin
            data_ram[wr_index][wr_offset] <= wr_data;
        end
        if (wr_line_en) begin
            tag_ram[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_ram[rd_index];
    assign rd_data  = data_ram[rd_index][rd_offset];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache serving the fetch stage;
// misses are refilled word by word from backing memory over req/ack.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int W          = WORD_WIDTH,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    output logic [W-1:0] read_inst,
    output logic         stall,
    output logic         addr_err,
    input  logic         flush,
    output logic         mem_req,
    output logic [W-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = W - IDX_W - OFF_W - 2;

    logic [OFF_W-1:0] pc_offset;
    logic [IDX_W-1:0] pc_index;
    logic [TAG_W-1:0] pc_tag;
    logic             misaligned;
    logic             hit;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [W-1:0]     rd_data;
    logic             wr_word_en;
    logic             wr_line_en;

    icache_state_e    state, state_d;
    logic [OFF_W-1:0] cnt, cnt_d;
    logic [TAG_W-1:0] miss_tag, miss_tag_d;
    logic [IDX_W-1:0] miss_index, miss_index_d;

    assign pc_offset  = pc[OFF_W+1:2];
    assign pc_index   = pc[OFF_W+2 +: IDX_W];
    assign pc_tag     = pc[W-1 -: TAG_W];
    assign misaligned = (pc[1:0] != 2'b00);
    assign hit        = rd_valid && (rd_tag == pc_tag) && !misaligned;

    icache_line_store #(
        .W          (W),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rd_index   (pc_index),
        .rd_offset  (pc_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_word_en (wr_word_en),
        .wr_line_en (wr_line_en),
        .wr_index   (miss_index),
        .wr_offset  (cnt),
        .wr_data    (mem_rdata),
        .wr_tag     (miss_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ICACHE_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
        miss_tag   <= miss_tag_d;
        miss_index <= miss_index_d;
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        miss_tag_d   = miss_tag;
        miss_index_d = miss_index;
        read_inst    = W'(ZERO_WORD);
        stall        = 1'b0;
        addr_err     = misaligned;
        mem_req      = 1'b0;
        mem_addr     = W'(ZERO_WORD);
        wr_word_en   = 1'b0;
        wr_line_en   = 1'b0;

        case (state)
            ICACHE_IDLE: begin
                if (hit) begin
                    read_inst = rd_data;
                end else if (!misaligned) begin
                    stall        = 1'b1;
                    state_d      = ICACHE_REFILL;
                    miss_tag_d   = pc_tag;
                    miss_index_d = pc_index;
                    cnt_d        = '0;
                end
            end
            ICACHE_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_index, cnt, 2'b00};
                stall    = 1'b1;
                if (mem_ack) begin
                    wr_word_en = 1'b1;
                    cnt_d      = cnt + 1'b1;
                    if (cnt == OFF_W'(LINE_WORDS - 1)) begin
                        wr_line_en = 1'b1;
                        state_d    = ICACHE_IDLE;
                    end
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase

        // Reset silences every output and blocks any write from a stray ack.
        if (rst) begin
            read_inst  = W'(ZERO_WORD);
            stall      = 1'b0;
            addr_err   = 1'b0;
            mem_req    = 1'b0;
            mem_addr   = W'(ZERO_WORD);
            wr_word_en = 1'b0;
            wr_line_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: expected refill addresses and fetch
// results are queued when stimulus is driven and compared when the DUT produces them.
module tb_icache_responder;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] read_inst;
    logic        stall;
    logic        addr_err;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] addr_q [$];
    logic [31:0] inst_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_delay = 0;
    int          ack_count = 0;
    int          wait_cnt  = 0;
    logic [31:0] first_addr;

    icache_responder dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .read_inst (read_inst),
        .stall     (stall),
        .addr_err  (addr_err),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        return a ^ 32'hDEAD0000;
    endfunction

    function automatic void push_line(input logic [31:0] a);
        for (int k = 0; k < 4; k++) addr_q.push_back((a & ~32'hF) + 32'(4 * k));
    endfunction

    // Backing memory: acks after ack_delay waiting cycles, checks each request address.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt == 0) first_addr = mem_addr;
                else chk("mem_addr_stable", mem_addr, first_addr);
                if (wait_cnt == ack_delay) begin
                    if (addr_q.size() == 0) chk("unexpected_req", mem_addr, 32'hFFFFFFFF);
                    else chk("mem_addr", mem_addr, addr_q.pop_front());
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                    ack_count++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic wait_done(output int stalls);
        stalls = 0;
        while (stall === 1'b1 && stalls < 200) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        if (stall !== 1'b0) chk("stall_timeout", {31'b0, stall}, 32'h0);
        if (inst_q.size() != 0) chk("read_inst", read_inst, inst_q.pop_front());
        chk("addr_err", {31'b0, addr_err}, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_stalls);
        int s;
        pc = a;
        inst_q.push_back(mem_word(a));
        if (exp_stalls > 0) push_line(a);
        #1;
        wait_done(s);
        chk("stall_cycles", 32'(s), 32'(exp_stalls));
    endtask

    initial begin
        int s;
        int acks_at_rst;
        rst   = 1'b1;
        pc    = '0;
        flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_read_inst", read_inst, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        rst = 1'b0;

        // Cold miss, then hits in the same line
        fetch(32'h0, 5);
        fetch(32'h8, 0);
        fetch(32'h4, 0);
        fetch(32'hC, 0);

        // Delayed ack: 4 cycles per word plus the miss-detect cycle
        ack_delay = 3;
        fetch(32'h40, 17);
        fetch(32'h44, 0);
        ack_delay = 0;

        // Conflict miss on index 0
        fetch(32'h100, 5);
        fetch(32'h10C, 0);
        fetch(32'h0, 5);

        // Flush in IDLE while hitting
        fetch(32'h4, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        chk("flush_stall", {31'b0, stall}, 32'h1);
        fetch(32'h4, 5);

        // Flush during refill: refilled line stays valid, others do not
        ack_delay = 3;
        pc = 32'h80;
        push_line(32'h80);
        inst_q.push_back(mem_word(32'h80));
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_done(s);
        ack_delay = 0;
        fetch(32'h84, 0);
        fetch(32'h0, 5);

        // Misaligned pc
        pc = 32'h2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mis_addr_err", {31'b0, addr_err}, 32'h1);
            chk("mis_stall", {31'b0, stall}, 32'h0);
            chk("mis_read_inst", read_inst, 32'h0);
            chk("mis_mem_req", {31'b0, mem_req}, 32'h0);
            @(posedge clk);
            #1;
        end

        // Reset mid-refill after two acks
        pc = 32'hC0;
        push_line(32'hC0);
        acks_at_rst = ack_count + 2;
        for (int i = 0; i < 50 && ack_count < acks_at_rst; i++) begin
            @(posedge clk);
            #1;
        end
        chk("acks_before_rst", 32'(ack_count), 32'(acks_at_rst));
        rst = 1'b1;
        addr_q.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mid_stall", {31'b0, stall}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_mid_no_ack", 32'(ack_count), 32'(acks_at_rst));
        chk("post_rst_miss", {31'b0, stall}, 32'h1);
        fetch(32'hC0, 5);
        fetch(32'hCC, 0);

        chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
